// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side byte FIFO.
//   byte_t                      one UART payload byte
//   UART_TX_FIFO_DEPTH_DEFAULT  default number of FIFO entries
package uart_pkg;

  typedef logic [7:0] byte_t;

  localparam int UART_TX_FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bundle of the producer-side write port and the transmitter-side en/data_in/rdy
// handshake of uart_tx_fifo.
//   slave  : the FIFO itself (takes wr_en/wr_data/tx_rdy, drives status and tx_en/tx_data)
//   master : the surroundings (producer plus transmitter)
// Optional feature macro: UART_TX_FIFO_LEVEL_EN adds level and almost_full.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_FIFO_DEPTH_DEFAULT
);
  localparam int AW = $clog2(DEPTH);

  logic  wr_en;
  byte_t wr_data;
  logic  full;
  logic  empty;
  logic  overflow;
  logic  tx_rdy;
  logic  tx_en;
  byte_t tx_data;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [AW:0] level;
  logic        almost_full;
`endif

  modport slave (
    input  wr_en, wr_data, tx_rdy,
    output full, empty, overflow, tx_en, tx_data
`ifdef UART_TX_FIFO_LEVEL_EN
    , output level, almost_full
`endif
  );

  modport master (
    output wr_en, wr_data, tx_rdy,
    input  full, empty, overflow, tx_en, tx_data
`ifdef UART_TX_FIFO_LEVEL_EN
    , input level, almost_full
`endif
  );

endinterface

// File: rtl/uart_byte_ram.sv
// DEPTH x 8 byte storage: synchronous write, asynchronous read by index, no reset.
//   clk      write clock
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  write byte
//   raddr_i  read index
//   rdata_o  byte at raddr_i (combinational)
module uart_byte_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_FIFO_DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  byte_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output byte_t         rdata_o
);

  byte_t mem_q [DEPTH];

  // NOTE: storage is deliberately left out of reset; occupancy is tracked by the
  // pointers and count, so stale contents are never observed and the array can map
  // onto plain RAM/LUT-RAM without a reset network.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO sitting directly upstream of the UART transmitter. Producers burst
// bytes in on a one-cycle write strobe; bytes leave one at a time on the
// transmitter's en/data_in/rdy handshake.
//   clk  system clock (posedge)
//   rst  asynchronous, active-high reset
//   bus  uart_tx_fifo_if.slave: wr_en, wr_data, full, empty, overflow,
//        tx_rdy, tx_en, tx_data (+ level, almost_full with the macro below)
// Optional feature macro: UART_TX_FIFO_LEVEL_EN exposes the occupancy count as
// level and a count >= DEPTH-2 flag as almost_full.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_FIFO_DEPTH_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          tx_en_q, tx_en_d;
  byte_t         tx_data_q, tx_data_d;
  logic          overflow_q, overflow_d;
  byte_t         rd_data;
  logic          full, empty, wr_accept, pop;

  // Status comes from the count so full and empty stay distinct when the pointers meet.
  assign full  = (count_q == COUNT_FULL);
  assign empty = (count_q == '0);

  // Fullness is judged before the edge: a write at full is dropped even if a pop
  // frees a slot on the same edge.
  assign wr_accept = bus.wr_en && !full;
  // The transmitter is still busy the cycle after a start strobe, so never issue twice in a row.
  assign pop = bus.tx_rdy && !tx_en_q && !empty;

  uart_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .we_i   (wr_accept),
    .waddr_i(wr_ptr_q),
    .wdata_i(bus.wr_data),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_data)
  );

  // NOTE: every next-state signal gets a default first so no path leaves it
  // unassigned; this is what keeps the combinational block free of latches.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    tx_en_d    = pop;
    overflow_d = bus.wr_en && full;

    if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      tx_data_d = rd_data;
    end

    case ({wr_accept, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = overflow_q;
  assign bus.tx_en    = tx_en_q;
  assign bus.tx_data  = tx_data_q;

`ifdef UART_TX_FIFO_LEVEL_EN
  assign bus.level       = count_q;
  assign bus.almost_full = (count_q >= COUNT_FULL - (AW+1)'(2));
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. A queue-based reference model tracks the
// bytes held, the expected start strobe, the byte presented and the overflow pulse.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  byte_t m_q[$];
  logic  m_tx_en;
  byte_t m_tx_data;
  logic  m_ovf;
  // Bytes seen on the DUT's tx_data while tx_en was high
  byte_t issued[$];

  // {tx_en, tx_data, full, empty, overflow, level[4:0], almost_full}
  function automatic logic [17:0] exp_vec();
    logic [17:0] v = '0;
    v[17]   = m_tx_en;
    v[16:9] = m_tx_data;
    v[8]    = (m_q.size() == DEPTH);
    v[7]    = (m_q.size() == 0);
    v[6]    = m_ovf;
`ifdef UART_TX_FIFO_LEVEL_EN
    v[5:1]  = 5'(m_q.size());
    v[0]    = (m_q.size() >= DEPTH - 2);
`endif
    return v;
  endfunction

  function automatic logic [17:0] obs_vec();
    logic [17:0] v = '0;
    v[17]   = bus.tx_en;
    v[16:9] = bus.tx_data;
    v[8]    = bus.full;
    v[7]    = bus.empty;
    v[6]    = bus.overflow;
`ifdef UART_TX_FIFO_LEVEL_EN
    v[5:1]  = bus.level;
    v[0]    = bus.almost_full;
`endif
    return v;
  endfunction

  // One clock: drive inputs, advance the model across the edge, settle #1 after it.
  task automatic step(input logic wr, input byte_t d, input logic rdy);
    logic full_pre, pop;
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.tx_rdy  = rdy;
    full_pre = (m_q.size() == DEPTH);
    pop      = rdy && !m_tx_en && (m_q.size() != 0);
    @(posedge clk);
    if (pop) m_tx_data = m_q.pop_front();
    m_tx_en = pop;
    if (wr && !full_pre) m_q.push_back(d);
    m_ovf = wr && full_pre;
    #1;
    if (bus.tx_en) issued.push_back(bus.tx_data);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_tx_en   = 1'b0;
    m_tx_data = 8'h00;
    m_ovf     = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((m_q.size() != 0 || m_tx_en) && n < 200) begin
      step(1'b0, 8'h00, 1'($urandom_range(0, 1)));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL %s drain cyc%0d: got %h expected %h", name, n, obs_vec(), exp_vec());
      end
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s drain timeout: got %0d cycles expected < 200", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.tx_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
    end
    checks++;
    if ({bus.tx_en, bus.tx_data, bus.overflow, bus.full, bus.empty} !== 12'b0_00000000_001) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b",
               {bus.tx_en, bus.tx_data, bus.overflow, bus.full, bus.empty}, 12'b0_00000000_001);
    end
  endtask

  task automatic test_single();
    step(1'b1, 8'hA5, 1'b1);
    checks++;
    if ({bus.tx_en, bus.empty} !== 2'b00) begin
      errors++;
      $display("FAIL single_after_write: got tx_en/empty=%b expected 00", {bus.tx_en, bus.empty});
    end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if ({bus.tx_en, bus.tx_data} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL single_issue: got %h expected %h", {bus.tx_en, bus.tx_data}, {1'b1, 8'hA5});
    end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if ({bus.tx_en, bus.empty} !== 2'b01) begin
      errors++;
      $display("FAIL single_after_issue: got tx_en/empty=%b expected 01", {bus.tx_en, bus.empty});
    end
  endtask

  task automatic test_fill_overflow();
    issued.delete();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fill cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: got %b expected 1", bus.full);
    end
    step(1'b1, 8'hFF, 1'b0);
    checks++;
    if ({bus.overflow, bus.full} !== 2'b11) begin
      errors++;
      $display("FAIL overflow_pulse: got ovf/full=%b expected 11", {bus.overflow, bus.full});
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if ({bus.overflow, bus.full} !== 2'b01) begin
      errors++;
      $display("FAIL overflow_clear: got ovf/full=%b expected 01", {bus.overflow, bus.full});
    end
    drain("fill");
    checks++;
    if (issued.size() != DEPTH) begin
      errors++;
      $display("FAIL fill_issue_count: got %0d expected %0d", issued.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (issued[i] !== 8'(i)) begin
          errors++;
          $display("FAIL fill_order[%0d]: got %h expected %h", i, issued[i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    byte_t expect_q[$];
    logic  prev_en = 1'b0;
    issued.delete();
    for (int i = 0; i < 300; i++) begin
      logic  wr = ($urandom_range(0, 2) != 0);
      byte_t d  = 8'($urandom);
      if (wr && m_q.size() < DEPTH) expect_q.push_back(d);
      step(wr, d, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      checks++;
      if (bus.tx_en && prev_en) begin
        errors++;
        $display("FAIL b2b_consecutive cyc%0d: got tx_en high twice expected once", i);
      end
      prev_en = bus.tx_en;
    end
    drain("b2b");
    checks++;
    if (issued.size() != expect_q.size()) begin
      errors++;
      $display("FAIL b2b_issue_count: got %0d expected %0d", issued.size(), expect_q.size());
    end else begin
      for (int i = 0; i < expect_q.size(); i++) begin
        if (issued[i] !== expect_q[i]) begin
          checks++;
          errors++;
          $display("FAIL b2b_order[%0d]: got %h expected %h", i, issued[i], expect_q[i]);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    issued.delete();
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'h50, 1'b1);
    checks++;
    if ({bus.tx_en, bus.full, bus.empty} !== 3'b100 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL simul_count15: got %h expected %h", obs_vec(), exp_vec());
    end
`ifdef UART_TX_FIFO_LEVEL_EN
    checks++;
    if (bus.level !== 5'd15) begin
      errors++;
      $display("FAIL simul_level15: got %0d expected 15", bus.level);
    end
`endif
    step(1'b1, 8'h51, 1'b0);
    checks++;
    if (bus.full !== 1'b1) begin
      errors++;
      $display("FAIL simul_full: got %b expected 1", bus.full);
    end
    step(1'b1, 8'h52, 1'b1);
    checks++;
    if ({bus.overflow, bus.full, bus.tx_en} !== 3'b101 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL simul_full_pop: got %h expected %h", obs_vec(), exp_vec());
    end
    drain("simul");
    checks++;
    if (issued.size() != 17 || issued[15] !== 8'h50 || issued[16] !== 8'h51) begin
      errors++;
      $display("FAIL simul_order: got %0d bytes expected 17 ending 50 51", issued.size());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(1, 255)), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.tx_en, bus.tx_data, bus.overflow, bus.full, bus.empty} !== 12'b0_00000000_001) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b",
               {bus.tx_en, bus.tx_data, bus.overflow, bus.full, bus.empty}, 12'b0_00000000_001);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    issued.delete();
    step(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h00, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (issued.size() != 1 || issued[0] !== 8'h3C) begin
      errors++;
      $display("FAIL post_reset_issue: got %0d bytes expected only 3c", issued.size());
    end
  endtask

`ifdef UART_TX_FIFO_LEVEL_EN
  task automatic test_level();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 8'(i + 8'h80), 1'b0);
      checks++;
      if ({bus.level, bus.almost_full} !== {5'(i), (i >= DEPTH - 2)}) begin
        errors++;
        $display("FAIL level_fill[%0d]: got %0d/%b expected %0d/%b",
                 i, bus.level, bus.almost_full, i, (i >= DEPTH - 2));
      end
    end
    drain("level");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_simultaneous();
    test_async_reset();
`ifdef UART_TX_FIFO_LEVEL_EN
    test_level();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
